// File: rtl/kyber_intt_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : kyber_intt_host_seq
// Description : Host sequencer for the single-PE Kyber multiplier core. It
//               buffers a natural-order polynomial, pushes it to the core in
//               the core's interleaved INTT order, runs the INTT, captures the
//               interleaved result and streams it back out in natural order.
// Revision    : 1.0 - initial release
// ============================================================================
module kyber_intt_host_seq #(
    parameter int COEF_W       = 12,
    parameter int N            = 256,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_data,
    input  logic              op_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err,
    output logic              load_a_i,
    output logic              load_b_i,
    output logic              read_a,
    output logic              read_b,
    output logic              start_ab,
    output logic              start_intt,
    output logic              load_a_f,
    output logic              load_b_f,
    output logic              start_fntt,
    output logic              start_pwm2,
    output logic [COEF_W-1:0] din,
    input  logic [COEF_W-1:0] dout,
    input  logic              done
);

    localparam int AW = $clog2(N);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_LOAD, S_PUSH, S_GAP, S_START, S_WAIT,
        S_POLL, S_POST, S_READ, S_RGAP, S_CAPT, S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_idx;
    logic [TW-1:0]     r_tmo;
    logic              r_sel;
    logic              r_err;
    logic [COEF_W-1:0] r_ibuf [N];
    logic [COEF_W-1:0] r_obuf [N];
    logic [AW:0]       r_rd_addr;
    logic              r_ov;
    logic              r_ol;
    logic [COEF_W-1:0] r_q;

    logic              w_in_acc;
    logic              w_rd_en;
    logic              w_tmo_hit;
    logic [AW-1:0]     w_push_addr;
    logic [AW-1:0]     w_capt_addr;

    assign w_in_acc  = (r_state == S_FILL) && in_valid;
    assign w_tmo_hit = (r_tmo == TW'(DONE_TIMEOUT - 1));
    // Core load order swaps the middle two of every group of four.
    assign w_push_addr = {r_idx[AW-1:2], r_idx[0], r_idx[1]};
    // Core emits even/odd halves interleaved: c -> (c>>1) + 128*(c&1).
    assign w_capt_addr = {r_idx[0], r_idx[AW-1:1]};
    assign w_rd_en = (r_state == S_DRAIN) && !r_rd_addr[AW] && (!r_ov || out_ready);

    assign in_ready   = (r_state == S_FILL);
    assign busy       = (r_state != S_IDLE) && (r_state != S_FILL);
    assign err        = r_err;
    assign out_valid  = r_ov;
    assign out_data   = r_q;
    assign out_last   = r_ov && r_ol;
    assign load_a_f   = 1'b0;
    assign load_b_f   = 1'b0;
    assign start_fntt = 1'b0;
    assign start_pwm2 = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        load_a_i   = 1'b0;
        load_b_i   = 1'b0;
        read_a     = 1'b0;
        read_b     = 1'b0;
        start_ab   = 1'b0;
        start_intt = 1'b0;
        din        = '0;
        unique case (r_state)
            S_IDLE:  w_next = S_FILL;
            S_FILL:  if (in_valid && r_idx == AW'(N - 1)) w_next = S_LOAD;
            S_LOAD: begin
                load_a_i = !r_sel;
                load_b_i = r_sel;
                w_next   = S_PUSH;
            end
            S_PUSH: begin
                din = r_ibuf[w_push_addr];
                if (r_idx == AW'(N - 1)) w_next = S_GAP;
            end
            S_GAP:   if (r_idx == AW'(1)) w_next = S_START;
            S_START: begin
                start_intt = 1'b1;
                start_ab   = r_sel;
                w_next     = S_WAIT;
            end
            S_WAIT:  if (r_idx == AW'(1)) w_next = S_POLL;
            S_POLL: begin
                if (done)           w_next = S_POST;
                else if (w_tmo_hit) w_next = S_FILL;
            end
            S_POST:  w_next = S_READ;
            S_READ: begin
                read_a = !r_sel;
                read_b = r_sel;
                w_next = S_RGAP;
            end
            S_RGAP:  if (r_idx == AW'(1)) w_next = S_CAPT;
            S_CAPT:  if (r_idx == AW'(N - 1)) w_next = S_DRAIN;
            S_DRAIN: if (r_ov && out_ready && r_ol) w_next = S_FILL;
            default: w_next = S_IDLE;
        endcase
    end

    // r_idx restarts on every state change and otherwise counts cycles,
    // except in FILL where it counts accepted beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
            r_tmo <= '0;
            r_sel <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_idx <= '0;
            end else if (r_state != S_FILL || w_in_acc) begin
                r_idx <= r_idx + AW'(1);
            end
            if (r_state != S_POLL) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_in_acc && r_idx == '0) begin
                r_sel <= op_sel;
            end
            if (r_state == S_POLL && !done && w_tmo_hit) begin
                r_err <= 1'b1;
            end else if (w_in_acc && r_idx == '0) begin
                r_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_ibuf[r_idx] <= in_data;
        end
        if (r_state == S_CAPT) begin
            r_obuf[w_capt_addr] <= dout;
        end
    end

    // The read register doubles as the output holding register: no new read
    // is issued while a presented beat is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_addr <= '0;
            r_ov      <= 1'b0;
            r_ol      <= 1'b0;
            r_q       <= '0;
        end else begin
            if (w_rd_en) begin
                r_q  <= r_obuf[r_rd_addr[AW-1:0]];
                r_ol <= (r_rd_addr == (AW + 1)'(N - 1));
                r_ov <= 1'b1;
            end else if (out_ready) begin
                r_ov <= 1'b0;
            end
            if (r_state != S_DRAIN) begin
                r_rd_addr <= '0;
            end else if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + (AW + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire
